lcd_bus_driver: RTL and testbench

- Downstream byte-level driver for the HD44780-style character LCD. The register/status display sequencers feed it one {RS, byte} per transaction with an iStart/oDone handshake.
- Generates the LCD bus timing: address setup, EN pulse, hold, then an execution wait sized by command type. Also enforces the power-up delay.
- Write-only: LCD_RW is tied low.

---
 rtl/lcd_bus_driver.sv | 122 ++++++++++++
 tb/tb_lcd_bus_driver.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_driver.sv
// Purpose : byte-level write driver for an HD44780-style character LCD bus.
// Latency : oDone fires 1+SETUP_CYC+EN_CYC+HOLD_CYC+exec cycles after the accepted start edge.
// Backpr. : oBusy high while powering up or mid-transaction; start edges seen while busy are dropped.
//
// Ports:
//   iCLK, iRST        clock and synchronous active-high reset
//   iDATA, iRS        byte and register select, captured when a start edge is accepted
//   iStart            request; only a 0->1 transition seen while idle starts a transaction
//   oDone, oBusy      one-cycle completion pulse / busy level
//   LCD_DATA, LCD_RS  LCD bus, held from acceptance until the next acceptance or reset
//   LCD_EN, LCD_RW    enable strobe and read/write (always write)
module lcd_bus_driver #(
    parameter int PWRUP_CYC     = 750000,
    parameter int SETUP_CYC     = 4,
    parameter int EN_CYC        = 16,
    parameter int HOLD_CYC      = 4,
    parameter int EXEC_CYC      = 2500,
    parameter int LONG_EXEC_CYC = 82000,
    parameter int CNT_W         = 20
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [7:0] iDATA,
    input  logic       iRS,
    input  logic       iStart,
    output logic       oDone,
    output logic       oBusy,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_EN,
    output logic       LCD_RW
);

    localparam logic [2:0] ST_PWRUP = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_SETUP = 3'd2;
    localparam logic [2:0] ST_PULSE = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_EXEC  = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    // Terminal counts: a timed state exits when the counter reaches length-1.
    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] exec_last;
    logic             start_q;
    logic             start_edge;
    logic             long_exec;
    logic             long_sel;

    // Rising edge of iStart; start_q samples every cycle in every state, so a
    // request held high across busy periods can never retrigger.
    assign start_edge = iStart & ~start_q;

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    assign long_sel  = ~iRS && (iDATA[7:2] == 6'd0) && (iDATA[1:0] != 2'd0);
    assign exec_last = long_exec ? LONG_LAST : EXEC_LAST;

    assign LCD_RW = 1'b0;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_PWRUP: if (cnt == PWRUP_LAST) state_nxt = ST_IDLE;
            ST_IDLE:  if (start_edge)        state_nxt = ST_SETUP;
            ST_SETUP: if (cnt == SETUP_LAST) state_nxt = ST_PULSE;
            ST_PULSE: if (cnt == EN_LAST)    state_nxt = ST_HOLD;
            ST_HOLD:  if (cnt == HOLD_LAST)  state_nxt = ST_EXEC;
            ST_EXEC:  if (cnt == exec_last)  state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            // Unused encoding: restart cleanly through the power-up wait.
            default:  state_nxt = ST_PWRUP;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= ST_PWRUP;
            cnt       <= '0;
            start_q   <= 1'b0;
            long_exec <= 1'b0;
            LCD_DATA  <= 8'h00;
            LCD_RS    <= 1'b0;
            LCD_EN    <= 1'b0;
            oDone     <= 1'b0;
            oBusy     <= 1'b1;
        end else begin
            start_q <= iStart;
            state   <= state_nxt;

            // One shared counter, restarted on every state change; it stays
            // parked at zero while idle.
            if ((state_nxt != state) || (state == ST_IDLE)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end

            if ((state == ST_IDLE) && start_edge) begin
                LCD_DATA  <= iDATA;
                LCD_RS    <= iRS;
                long_exec <= long_sel;
            end

            // Outputs are registered off the next state so they line up
            // exactly with the state they belong to.
            LCD_EN <= (state_nxt == ST_PULSE);
            oDone  <= (state_nxt == ST_DONE);
            oBusy  <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
        end
    end

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Purpose : self-checking bench for lcd_bus_driver with short timing parameters.
// Latency : cycle numbers are relative to the cycle whose clock edge samples the start.
// Backpr. : iStart driven directly, held or pulsed per scenario; every loop is cycle-bounded.
module tb_lcd_bus_driver;

    localparam int S = 2;
    localparam int E = 3;
    localparam int H = 2;
    localparam int X = 5;
    localparam int L = 20;
    localparam int P = 10;

    logic       clk;
    logic       rst;
    logic       start;
    logic       rs_i;
    logic [7:0] data_i;
    logic       done;
    logic       busy;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_en;
    logic       lcd_rw;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         exp_done;
        int         exp_en_first;
        int         exp_en_last;
    } vec_t;

    vec_t tbl [8];

    lcd_bus_driver #(
        .PWRUP_CYC     (P),
        .SETUP_CYC     (S),
        .EN_CYC        (E),
        .HOLD_CYC      (H),
        .EXEC_CYC      (X),
        .LONG_EXEC_CYC (L),
        .CNT_W         (8)
    ) dut (
        .iCLK     (clk),
        .iRST     (rst),
        .iDATA    (data_i),
        .iRS      (rs_i),
        .iStart   (start),
        .oDone    (done),
        .oBusy    (busy),
        .LCD_DATA (lcd_data),
        .LCD_RS   (lcd_rs),
        .LCD_EN   (lcd_en),
        .LCD_RW   (lcd_rw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive this cycle's inputs, then advance to just after the next edge.
    task automatic step(input logic s, input logic r, input logic [7:0] d);
        start  = s;
        rs_i   = r;
        data_i = d;
        @(posedge clk);
        #1;
    endtask

    // EN window for a transaction accepted in cycle t0.
    function automatic logic [127:0] en_bits(input int t0);
        logic [127:0] m;
        m = '0;
        for (int k = t0 + 1 + S; k <= t0 + S + E; k++) m[k] = 1'b1;
        return m;
    endfunction

    function automatic logic [127:0] done_bit(input int t0, input int x);
        logic [127:0] m;
        m = '0;
        m[t0 + 1 + S + E + H + x] = 1'b1;
        return m;
    endfunction

    initial begin
        logic [11:0]  acc;
        logic [127:0] en_m;
        logic [127:0] done_m;
        logic [127:0] busy_m;
        logic [127:0] exp_m;
        logic [8:0]   first_bus;
        int           en_first;
        int           en_last;
        int           en_pulses;
        int           done_c;
        int           done_cnt;
        int           busy_cnt;
        logic         prev_en;
        int           m_t0;
        int           m_D;
        logic         m_rs;
        logic [7:0]   m_data;
        logic         m_prev;
        logic         s;
        logic         r;
        logic [7:0]   d;
        int           rel;
        logic [13:0]  exp_v;

        tbl[0] = '{1'b1, 8'h41, 13, 3, 5};
        tbl[1] = '{1'b0, 8'h01, 28, 3, 5};
        tbl[2] = '{1'b0, 8'h03, 28, 3, 5};
        tbl[3] = '{1'b0, 8'h02, 28, 3, 5};
        tbl[4] = '{1'b0, 8'h06, 13, 3, 5};
        tbl[5] = '{1'b0, 8'h00, 13, 3, 5};
        tbl[6] = '{1'b1, 8'h01, 13, 3, 5};
        tbl[7] = '{1'b0, 8'h04, 13, 3, 5};

        // ---- reset and power-up wait, with an ignored start pulse at cycle 5
        rst    = 1'b1;
        start  = 1'b0;
        rs_i   = 1'b0;
        data_i = 8'h00;
        repeat (3) step(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        acc = '0;
        for (int c = 1; c <= 30; c++) begin
            check($sformatf("pwrup_busy_c%0d", c), busy, (c <= P));
            acc = acc | {lcd_en, done, lcd_rs, lcd_rw, lcd_data};
            step(c == 5, 1'b0, 8'h00);
        end
        check("pwrup_lcd_quiet", acc, 12'h000);

        // ---- single transactions, regshow handshake, from the vector table
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 8'h00);
            en_first  = -1;
            en_last   = -1;
            en_pulses = 0;
            done_c    = -1;
            done_cnt  = 0;
            busy_cnt  = 0;
            prev_en   = 1'b0;
            first_bus = '0;
            for (int c = 0; c < 36; c++) begin
                if (lcd_en === 1'b1) begin
                    if (en_first < 0) en_first = c;
                    en_last = c;
                    if (!prev_en) en_pulses++;
                end
                prev_en = (lcd_en === 1'b1);
                if (done === 1'b1) begin
                    done_cnt++;
                    if (done_c < 0) done_c = c;
                end
                if (busy === 1'b1) busy_cnt++;
                if (c == 1) first_bus = {lcd_rs, lcd_data};
                // Inputs change after acceptance to prove they were latched.
                step(done_c < 0, (c == 0) ? tbl[i].rs : ~tbl[i].rs,
                     (c == 0) ? tbl[i].d : ~tbl[i].d);
            end
            check($sformatf("vec%0d_en_first", i), en_first, tbl[i].exp_en_first);
            check($sformatf("vec%0d_en_last", i), en_last, tbl[i].exp_en_last);
            check($sformatf("vec%0d_en_pulses", i), en_pulses, 1);
            check($sformatf("vec%0d_done_cycle", i), done_c, tbl[i].exp_done);
            check($sformatf("vec%0d_done_count", i), done_cnt, 1);
            check($sformatf("vec%0d_busy_cycles", i), busy_cnt, tbl[i].exp_done - 1);
            check($sformatf("vec%0d_bus_c1", i), first_bus, {tbl[i].rs, tbl[i].d});
            check($sformatf("vec%0d_bus_held", i), {lcd_rs, lcd_data}, {tbl[i].rs, tbl[i].d});
        end

        // ---- back-to-back: start dropped at 13, re-raised at 14
        step(1'b0, 1'b0, 8'h00);
        en_m   = '0;
        done_m = '0;
        for (int c = 0; c < 45; c++) begin
            en_m[c]   = lcd_en;
            done_m[c] = done;
            step((c <= 12) || (c >= 14 && c <= 26), 1'b1, 8'h30);
        end
        check("b2b_en", en_m, en_bits(0) | en_bits(14));
        check("b2b_done", done_m, done_bit(0, X) | done_bit(14, X));

        // ---- rise at cycle 6 mid-transaction and held: must not retrigger
        step(1'b0, 1'b0, 8'h00);
        en_m   = '0;
        done_m = '0;
        for (int c = 0; c < 76; c++) begin
            en_m[c]   = lcd_en;
            done_m[c] = done;
            step((c == 0) || (c >= 6 && c <= 40) || (c >= 43 && c <= 60), 1'b0, 8'h06);
        end
        check("held_en", en_m, en_bits(0) | en_bits(43));
        check("held_done", done_m, done_bit(0, X) | done_bit(43, X));

        // ---- reset asserted in cycle 4 while EN is high
        step(1'b0, 1'b0, 8'h00);
        en_m   = '0;
        done_m = '0;
        busy_m = '0;
        for (int c = 0; c < 41; c++) begin
            en_m[c]   = lcd_en;
            done_m[c] = done;
            busy_m[c] = busy;
            if (c == 4) check("rstmid_en_c4", lcd_en, 1'b1);
            if (c == 5) check("rstmid_c5", {lcd_en, lcd_data, lcd_rs, busy}, {1'b0, 8'h00, 1'b0, 1'b1});
            rst = (c == 4);
            step(c <= 3, 1'b1, 8'h55);
        end
        rst = 1'b0;
        exp_m    = en_bits(0);
        exp_m[5] = 1'b0;
        check("rstmid_en", en_m, exp_m);
        check("rstmid_no_done", done_m, 128'h0);
        exp_m = '0;
        for (int k = 1; k <= 4 + P; k++) exp_m[k] = 1'b1;
        check("rstmid_busy", busy_m, exp_m);

        // ---- randomized traffic against a timeline model
        m_t0   = -1000;
        m_D    = 1 + S + E + H + X;
        m_rs   = 1'b0;
        m_data = 8'h00;
        m_prev = 1'b0;
        for (int c = 0; c < 800; c++) begin
            rel   = c - m_t0;
            exp_v = {(rel >= 1 + S) && (rel <= S + E), rel == m_D, (rel >= 1) && (rel < m_D),
                     m_rs, m_data, 1'b0};
            check($sformatf("rand_c%0d", c), {lcd_en, done, busy, lcd_rs, lcd_data, lcd_rw}, exp_v);
            s = ($urandom_range(0, 3) == 0) ? ~m_prev : m_prev;
            r = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            if ((c >= m_t0 + m_D + 1) && s && !m_prev) begin
                m_t0   = c;
                m_rs   = r;
                m_data = d;
                m_D    = 1 + S + E + H + ((!r && d <= 8'h03 && d != 8'h00) ? L : X);
            end
            m_prev = s;
            step(s, r, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
